uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 114 +++++++++++
 tb/tb_uart_tx_frame.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: FIFO-fed UART transmitter sending start, LSB-first data, optional parity and stop bits
// Ports: CLK bit-rate clock; RST sync active-high reset; FIFO_EMPTY/FIFO_RD_DATA/FIFO_RD_INC FIFO read
// handshake (combinational head word, pop on the edge where FIFO_RD_INC=1); PAR_EN/PAR_TYP parity
// config latched per frame (PAR_TYP 0 = even, 1 = odd); TX_OUT registered serial line, idle high;
// BUSY registered frame-in-progress flag.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_RD_INC,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t r_state, w_state;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic [CW-1:0] r_bit_cnt, w_bit_cnt;
  logic r_stop_cnt, w_stop_cnt;
  logic r_par_en, w_par_en;
  logic r_par_bit, w_par_bit;
  logic r_tx, w_tx;
  logic r_busy, w_busy;
  logic w_last_stop, w_last_bit;
  assign w_last_stop = r_state == STOP && r_stop_cnt == 1'(STOP_BITS - 1);
  assign w_last_bit = r_bit_cnt == CW'(DATA_WIDTH - 1);
  // Popping in the last stop cycle chains frames with no idle gap.
  assign FIFO_RD_INC = !RST && !FIFO_EMPTY && (r_state == IDLE || w_last_stop);
  assign TX_OUT = r_tx;
  assign BUSY = r_busy;
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_bit_cnt = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_par_en = r_par_en;
    w_par_bit = r_par_bit;
    w_tx = r_tx;
    w_busy = r_busy;
    if (FIFO_RD_INC) begin
      w_state = START;
      w_shift = FIFO_RD_DATA;
      w_par_en = PAR_EN;
      w_par_bit = ^FIFO_RD_DATA ^ PAR_TYP;
      w_tx = 1'b0;
      w_busy = 1'b1;
    end else begin
      case (r_state)
        START: begin
          w_state = DATA;
          w_tx = r_shift[0];
          w_shift = r_shift >> 1;
          w_bit_cnt = '0;
        end
        DATA: begin
          if (!w_last_bit) begin
            w_tx = r_shift[0];
            w_shift = r_shift >> 1;
            w_bit_cnt = r_bit_cnt + 1'b1;
          end else if (r_par_en) begin
            w_state = PARITY;
            w_tx = r_par_bit;
          end else begin
            w_state = STOP;
            w_tx = 1'b1;
            w_stop_cnt = 1'b0;
          end
        end
        PARITY: begin
          w_state = STOP;
          w_tx = 1'b1;
          w_stop_cnt = 1'b0;
        end
        STOP: begin
          if (!w_last_stop) begin
            w_stop_cnt = r_stop_cnt + 1'b1;
          end else begin
            w_state = IDLE;
            w_tx = 1'b1;
            w_busy = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit_cnt <= '0;
      r_stop_cnt <= 1'b0;
      r_par_en <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_bit_cnt <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_par_en <= w_par_en;
      r_par_bit <= w_par_bit;
      r_tx <= w_tx;
      r_busy <= w_busy;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed self-checking bench for uart_tx_frame (one and two stop bit instances)
module tb_uart_tx_frame;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic par_en = 1'b0;
  logic par_typ = 1'b0;
  logic empty0, empty1, inc0, inc1, tx0, tx1, busy0, busy1;
  logic [7:0] data0, data1;
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  int rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0, n0 = 0, n1 = 0;
  logic [63:0] cap_tx, cap_busy, cap_inc;
  int cap_n = 0;
  int checks = 0;
  int fails = 0;
  int n_before;
  always #5 clk = ~clk;
  assign empty0 = rd0 == wr0;
  assign empty1 = rd1 == wr1;
  assign data0 = mem0[rd0[3:0]];
  assign data1 = mem1[rd1[3:0]];
  always @(posedge clk) begin
    if (inc0) begin
      rd0 <= rd0 + 1;
      n0 <= n0 + 1;
    end
    if (inc1) begin
      rd1 <= rd1 + 1;
      n1 <= n1 + 1;
    end
  end
  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut0 (
    .CLK(clk), .RST(rst), .FIFO_EMPTY(empty0), .FIFO_RD_DATA(data0), .FIFO_RD_INC(inc0),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx0), .BUSY(busy0)
  );
  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut1 (
    .CLK(clk), .RST(rst), .FIFO_EMPTY(empty1), .FIFO_RD_DATA(data1), .FIFO_RD_INC(inc1),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx1), .BUSY(busy1)
  );
  task automatic push(input int s, input logic [7:0] b);
    if (s == 0) begin
      mem0[wr0[3:0]] = b;
      wr0++;
    end else begin
      mem1[wr1[3:0]] = b;
      wr1++;
    end
  endtask
  task automatic capture(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cap_tx[cap_n] = s != 0 ? tx1 : tx0;
      cap_busy[cap_n] = s != 0 ? busy1 : busy0;
      cap_inc[cap_n] = s != 0 ? inc1 : inc0;
      cap_n++;
    end
  endtask
  task automatic clear_cap();
    cap_n = 0;
    cap_tx = '0;
    cap_busy = '0;
    cap_inc = '0;
  endtask
  task automatic test_reset();
    push(0, 8'h96);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (tx0 !== 1'b1) begin fails++; $display("FAIL reset_tx cycle %0d: got %b want 1", c, tx0); end
      checks++;
      if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy cycle %0d: got %b want 0", c, busy0); end
      checks++;
      if (inc0 !== 1'b0) begin fails++; $display("FAIL reset_rd_inc cycle %0d: got %b want 0", c, inc0); end
      checks++;
      if (tx1 !== 1'b1 || busy1 !== 1'b0) begin fails++; $display("FAIL reset_dut1 cycle %0d: got tx %b busy %b want 1 0", c, tx1, busy1); end
    end
    checks++;
    if (n0 !== 0) begin fails++; $display("FAIL reset_no_pop: got %0d pops want 0", n0); end
    rst = 1'b0;
    #1;
    checks++;
    if (inc0 !== 1'b1) begin fails++; $display("FAIL reset_first_pop: got %b want 1", inc0); end
    clear_cap();
    capture(0, 11);
    checks++;
    if (cap_tx[10:0] !== {1'b1, 1'b1, 8'h96, 1'b0}) begin fails++; $display("FAIL reset_frame_tx: got %b want %b", cap_tx[10:0], {1'b1, 1'b1, 8'h96, 1'b0}); end
    checks++;
    if (n0 !== 1) begin fails++; $display("FAIL reset_frame_pops: got %0d want 1", n0); end
  endtask
  task automatic test_single();
    par_en = 1'b0;
    n_before = n0;
    push(0, 8'hA5);
    #1;
    checks++;
    if (inc0 !== 1'b1) begin fails++; $display("FAIL single_pop: got %b want 1", inc0); end
    clear_cap();
    capture(0, 11);
    checks++;
    if (cap_tx[10:0] !== 11'b11101001010) begin fails++; $display("FAIL single_tx: got %b want %b", cap_tx[10:0], 11'b11101001010); end
    checks++;
    if (cap_busy[10:0] !== 11'b01111111111) begin fails++; $display("FAIL single_busy: got %b want %b", cap_busy[10:0], 11'b01111111111); end
    checks++;
    if (cap_inc[10:0] !== 11'b0) begin fails++; $display("FAIL single_rd_inc: got %b want 0", cap_inc[10:0]); end
    checks++;
    if (n0 - n_before !== 1) begin fails++; $display("FAIL single_pops: got %0d want 1", n0 - n_before); end
  endtask
  task automatic test_parity(input logic [7:0] d, input logic typ, input logic p);
    par_en = 1'b1;
    par_typ = typ;
    push(0, d);
    #1;
    clear_cap();
    capture(0, 12);
    checks++;
    if (cap_tx[11:0] !== {1'b1, 1'b1, p, d, 1'b0}) begin fails++; $display("FAIL parity_tx %h typ %b: got %b want %b", d, typ, cap_tx[11:0], {1'b1, 1'b1, p, d, 1'b0}); end
    checks++;
    if (cap_busy[11:0] !== 12'h7FF) begin fails++; $display("FAIL parity_busy %h: got %b want %b", d, cap_busy[11:0], 12'h7FF); end
  endtask
  task automatic test_back_to_back();
    par_en = 1'b0;
    par_typ = 1'b0;
    n_before = n1;
    push(1, 8'h11);
    push(1, 8'h22);
    push(1, 8'h33);
    #1;
    checks++;
    if (inc1 !== 1'b1) begin fails++; $display("FAIL b2b_first_pop: got %b want 1", inc1); end
    clear_cap();
    capture(1, 34);
    checks++;
    if (cap_tx[33:0] !== {1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0}) begin
      fails++;
      $display("FAIL b2b_tx: got %b want %b", cap_tx[33:0], {1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0});
    end
    checks++;
    if (cap_busy[33:0] !== {1'b0, 33'h1_FFFF_FFFF}) begin fails++; $display("FAIL b2b_busy: got %b want %b", cap_busy[33:0], {1'b0, 33'h1_FFFF_FFFF}); end
    checks++;
    if (cap_inc[33:0] !== 34'h0_0020_0400) begin fails++; $display("FAIL b2b_rd_inc_align: got %b want %b", cap_inc[33:0], 34'h0_0020_0400); end
    checks++;
    if (n1 - n_before !== 3) begin fails++; $display("FAIL b2b_pops: got %0d want 3", n1 - n_before); end
    checks++;
    if (empty1 !== 1'b1) begin fails++; $display("FAIL b2b_empty: got %b want 1", empty1); end
  endtask
  task automatic test_config_change();
    par_en = 1'b0;
    par_typ = 1'b0;
    push(0, 8'h5A);
    push(0, 8'h80);
    #1;
    clear_cap();
    capture(0, 3);
    par_en = 1'b1;
    capture(0, 19);
    checks++;
    if (cap_tx[21:0] !== {1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 8'h5A, 1'b0}) begin
      fails++;
      $display("FAIL cfg_tx: got %b want %b", cap_tx[21:0], {1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 8'h5A, 1'b0});
    end
    checks++;
    if (cap_inc[21:0] !== 22'h200) begin fails++; $display("FAIL cfg_rd_inc_align: got %b want %b", cap_inc[21:0], 22'h200); end
    checks++;
    if (cap_busy[21:0] !== {1'b0, 21'h1F_FFFF}) begin fails++; $display("FAIL cfg_busy: got %b want %b", cap_busy[21:0], {1'b0, 21'h1F_FFFF}); end
  endtask
  task automatic test_reset_mid_frame();
    par_en = 1'b0;
    n_before = n0;
    push(0, 8'hFF);
    #1;
    clear_cap();
    capture(0, 6);
    checks++;
    if (cap_tx[5:0] !== 6'b111110 || cap_busy[5:0] !== 6'b111111) begin fails++; $display("FAIL mid_pre_reset: got tx %b busy %b want 111110 111111", cap_tx[5:0], cap_busy[5:0]); end
    rst = 1'b1;
    push(0, 8'h3C);
    #1;
    checks++;
    if (inc0 !== 1'b0) begin fails++; $display("FAIL mid_rd_inc_in_reset: got %b want 0", inc0); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || inc0 !== 1'b0) begin fails++; $display("FAIL mid_reset cycle %0d: got tx %b busy %b inc %b want 1 0 0", c, tx0, busy0, inc0); end
    end
    checks++;
    if (n0 - n_before !== 1) begin fails++; $display("FAIL mid_pops_in_reset: got %0d want 1", n0 - n_before); end
    rst = 1'b0;
    #1;
    checks++;
    if (inc0 !== 1'b1) begin fails++; $display("FAIL mid_pop_after_reset: got %b want 1", inc0); end
    clear_cap();
    capture(0, 11);
    checks++;
    if (cap_tx[10:0] !== {1'b1, 1'b1, 8'h3C, 1'b0}) begin fails++; $display("FAIL mid_next_frame_tx: got %b want %b", cap_tx[10:0], {1'b1, 1'b1, 8'h3C, 1'b0}); end
    checks++;
    if (cap_busy[10:0] !== 11'b01111111111) begin fails++; $display("FAIL mid_next_frame_busy: got %b want %b", cap_busy[10:0], 11'b01111111111); end
    checks++;
    if (n0 - n_before !== 2) begin fails++; $display("FAIL mid_total_pops: got %0d want 2", n0 - n_before); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_parity(8'h03, 1'b0, 1'b0);
    test_parity(8'h03, 1'b1, 1'b1);
    test_parity(8'h07, 1'b0, 1'b1);
    test_back_to_back();
    test_config_change();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
